// File: rtl/quad_scan_mapper.sv
// Forward-mapping scan engine: walks every source texel in raster order and emits the
// bilinearly interpolated destination coordinate of the latched quad over valid/ready.
module quad_scan_mapper #(
    parameter int XW      = 10,
    parameter int YW      = 9,
    parameter int FRAC    = 10,
    parameter int SW_LOG2 = 9,
    parameter int SH_LOG2 = 8,
    parameter int DST_W   = 640,
    parameter int DST_H   = 480,
    parameter int CLIP    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_flag,
    input  logic [XW-1:0]      ax,
    input  logic [XW-1:0]      bx,
    input  logic [XW-1:0]      cx,
    input  logic [XW-1:0]      dx,
    input  logic [YW-1:0]      ay,
    input  logic [YW-1:0]      by,
    input  logic [YW-1:0]      cy,
    input  logic [YW-1:0]      dy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XW-1:0]      out_x,
    output logic [YW-1:0]      out_y,
    output logic [SW_LOG2-1:0] out_src_x,
    output logic [SH_LOG2-1:0] out_src_y,
    output logic               out_offscreen,
    output logic               out_last,
    output logic               busy
);
    localparam int AXW = XW + FRAC + 2;
    localparam int AYW = YW + FRAC + 2;
    localparam int RXW = XW + 2;
    localparam int RYW = YW + 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_LINE  = 3'd2;
    localparam logic [2:0] S_PIXEL = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic signed [AXW-1:0] HALF_X = AXW'(2 ** (FRAC - 1));
    localparam logic signed [AYW-1:0] HALF_Y = AYW'(2 ** (FRAC - 1));
    localparam logic signed [RXW-1:0] LIM_X  = RXW'(DST_W);
    localparam logic signed [RYW-1:0] LIM_Y  = RYW'(DST_H);

    function automatic logic signed [AXW-1:0] load_x(input logic [XW-1:0] v);
        return $signed({2'b00, v, {FRAC{1'b0}}});
    endfunction

    function automatic logic signed [AYW-1:0] load_y(input logic [YW-1:0] v);
        return $signed({2'b00, v, {FRAC{1'b0}}});
    endfunction

    // Round half up, then drop the fraction with sign preserved.
    function automatic logic signed [RXW-1:0] rnd_x(input logic signed [AXW-1:0] p);
        logic signed [AXW-1:0] t;
        t = p + HALF_X;
        return t[AXW-1:FRAC];
    endfunction

    function automatic logic signed [RYW-1:0] rnd_y(input logic signed [AYW-1:0] p);
        logic signed [AYW-1:0] t;
        t = p + HALF_Y;
        return t[AYW-1:FRAC];
    endfunction

    function automatic logic [XW-1:0] clamp_x(input logic signed [RXW-1:0] r);
        return r[RXW-1] ? '0 : r[XW-1:0];
    endfunction

    function automatic logic [YW-1:0] clamp_y(input logic signed [RYW-1:0] r);
        return r[RYW-1] ? '0 : r[YW-1:0];
    endfunction

    logic [2:0]            r_state;
    logic [SW_LOG2-1:0]    r_src_x;
    logic [SH_LOG2-1:0]    r_src_y;
    logic [XW-1:0]         r_cx, r_dx;
    logic [YW-1:0]         r_cy, r_dy;
    logic signed [AXW-1:0] r_lx, r_rx, r_slx, r_srx, r_px, r_spx;
    logic signed [AYW-1:0] r_ly, r_ry, r_sly, r_sry, r_py, r_spy;

    logic                  r_out_valid;
    logic                  r_out_off;
    logic                  r_out_last;
    logic [XW-1:0]         r_out_x;
    logic [YW-1:0]         r_out_y;
    logic [SW_LOG2-1:0]    r_out_sx;
    logic [SH_LOG2-1:0]    r_out_sy;

    logic                  w_adv;
    logic                  w_last_col;
    logic                  w_last_row;
    logic                  w_off;
    logic                  w_drop;
    logic signed [RXW-1:0] w_rx;
    logic signed [RYW-1:0] w_ry;

    assign w_adv      = !r_out_valid || out_ready;
    assign w_last_col = &r_src_x;
    assign w_last_row = &r_src_y;
    assign w_rx       = rnd_x(r_px);
    assign w_ry       = rnd_y(r_py);
    assign w_off      = w_rx[RXW-1] || w_ry[RYW-1] || (w_rx >= LIM_X) || (w_ry >= LIM_Y);
    assign w_drop     = (CLIP != 0) && w_off;

    // Accumulator datapath: L/R walk down the quad's left and right edges, P walks a line.
    always_ff @(posedge clk) begin
        if (frame_flag) begin
            r_lx <= load_x(ax);
            r_rx <= load_x(bx);
            r_ly <= load_y(ay);
            r_ry <= load_y(by);
            r_cx <= cx;
            r_dx <= dx;
            r_cy <= cy;
            r_dy <= dy;
        end else begin
            case (r_state)
                S_SETUP: begin
                    r_slx <= (load_x(r_dx) - r_lx) >>> SH_LOG2;
                    r_srx <= (load_x(r_cx) - r_rx) >>> SH_LOG2;
                    r_sly <= (load_y(r_dy) - r_ly) >>> SH_LOG2;
                    r_sry <= (load_y(r_cy) - r_ry) >>> SH_LOG2;
                end
                S_LINE: begin
                    r_px  <= r_lx;
                    r_py  <= r_ly;
                    r_spx <= (r_rx - r_lx) >>> SW_LOG2;
                    r_spy <= (r_ry - r_ly) >>> SW_LOG2;
                end
                S_PIXEL: begin
                    if (w_adv) begin
                        r_px <= r_px + r_spx;
                        r_py <= r_py + r_spy;
                        if (w_last_col) begin
                            r_lx <= r_lx + r_slx;
                            r_rx <= r_rx + r_srx;
                            r_ly <= r_ly + r_sly;
                            r_ry <= r_ry + r_sry;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Walk control and the registered output beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_src_x     <= '0;
            r_src_y     <= '0;
            r_out_valid <= 1'b0;
            r_out_off   <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_sx    <= '0;
            r_out_sy    <= '0;
        end else if (frame_flag) begin
            r_state     <= S_SETUP;
            r_src_x     <= '0;
            r_src_y     <= '0;
            r_out_valid <= 1'b0;
            r_out_off   <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
            case (r_state)
                S_IDLE:  ;
                S_SETUP: r_state <= S_LINE;
                S_LINE:  r_state <= S_PIXEL;
                S_PIXEL: begin
                    if (w_adv) begin
                        r_out_valid <= !w_drop;
                        if (!w_drop) begin
                            r_out_x    <= clamp_x(w_rx);
                            r_out_y    <= clamp_y(w_ry);
                            r_out_sx   <= r_src_x;
                            r_out_sy   <= r_src_y;
                            r_out_off  <= w_off;
                            r_out_last <= w_last_col && w_last_row;
                        end
                        r_src_x <= r_src_x + SW_LOG2'(1);
                        if (w_last_col) begin
                            r_src_y <= r_src_y + SH_LOG2'(1);
                            r_state <= w_last_row ? S_DONE : S_LINE;
                        end
                    end
                end
                S_DONE: begin
                    if (w_adv) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A clipped final texel leaves DONE with no beat pending, so busy is already low there.
    assign busy          = (r_state != S_IDLE) && ((r_state != S_DONE) || r_out_valid);
    assign out_valid     = r_out_valid;
    assign out_x         = r_out_x;
    assign out_y         = r_out_y;
    assign out_src_x     = r_out_sx;
    assign out_src_y     = r_out_sy;
    assign out_offscreen = r_out_off;
    assign out_last      = r_out_last;

endmodule
